dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port synchronous data memory between the core MEM-stage load/store port and a
//  DMA/loader port. Core has priority; a fairness counter forces one DMA slot after a run of core
//  grants while DMA waits. Routes 1-cycle-latency read data back to the granted requester and
//  raises the core stall when the core is refused. Sits between the memory stage and the dmem array.
// PARAMETERS
//  ADDR_W          13   byte-address bits decoded (2048 words x 4 bytes); higher bits = out of range
//  MAX_CORE_BURST  4    consecutive core grants allowed while dma_req_i is pending (>=1)
// PORTS
//  clk_i          in   1        clock, rising edge
//  rst_i          in   1        reset, asynchronous, active-high
//  core_req_i     in   1        core access request
//  core_we_i      in   1        1 = store, 0 = load
//  core_be_i      in   4        byte enables (stores only)
//  core_addr_i    in   XLEN     byte address, word-aligned
//  core_wdata_i   in   XLEN     store data
//  core_gnt_o     out  1        request accepted this cycle
//  core_stall_o   out  1        core_req_i & ~core_gnt_o
//  core_rvalid_o  out  1        load data valid (cycle after grant)
//  core_rdata_o   out  XLEN     load data
//  dma_req_i/dma_we_i/dma_be_i/dma_addr_i/dma_wdata_i   in   as core
//  dma_gnt_o, dma_rvalid_o  out 1;  dma_rdata_o  out XLEN      as core
//  mem_req_o      out  1        memory access strobe
//  mem_we_o       out  1        memory write
//  mem_be_o       out  4        memory byte enables
//  mem_addr_o     out  ADDR_W-2 word index = addr[ADDR_W-1:2]
//  mem_wdata_o    out  XLEN     write data
//  mem_rdata_i    in   XLEN     read data, valid the cycle after a read strobe
// BEHAVIOUR
//  - Reset (async): state=ARB_CORE, burst_cnt=0, resp_owner=NONE; all *_gnt/*_rvalid/mem_req = 0.
//  - Handshake: transfer occurs when req & gnt in same cycle; gnt is combinational from req+state.
//    At most one grant per cycle; a requester holds req/we/be/addr/wdata stable until granted.
//  - FSM ARB_CORE: core_req -> core_gnt; else dma_req -> dma_gnt. Each core grant with dma_req_i
//    high increments burst_cnt; burst_cnt reaching MAX_CORE_BURST -> ARB_DMA_FORCED. Cycle without
//    dma_req_i clears burst_cnt. Any DMA grant clears burst_cnt.
//  - FSM ARB_DMA_FORCED: dma_req -> dma_gnt, core refused (stall); return to ARB_CORE next cycle.
//    If dma_req_i dropped, grant core as in ARB_CORE and return to ARB_CORE.
//  - mem_* driven combinationally from the granted requester; zero when no grant.
//  - Out of range (addr[XLEN-1:ADDR_W] != 0): granted, mem_req_o=0; a load returns rvalid, rdata=0.
//  - Loads: resp_owner registered at grant; next cycle owner's rvalid=1, rdata=mem_rdata_i (or 0
//    for out of range). Non-owner rdata=0. Stores produce no rvalid.
//  - Back-to-back grants allowed every cycle (read response pipelined alongside next request).
//  - Reset mid-operation: pending response dropped, no rvalid after reset release.
//  - Latency: grant 0 cycles when uncontended; load data 1 cycle after grant.
// STRUCTURE
//  - riscv_pkg: arb_state_e {ARB_CORE, ARB_DMA_FORCED}, arb_owner_e {OWN_NONE, OWN_CORE, OWN_DMA},
//    mem_req_t struct {we, be, addr, wdata}; XLEN reused.
//  - One sub-module: dmem_arb_fair_cnt (burst counter + forced-slot flag); rest inline.
// TESTING
//  - Core only: load @0x0000_0010 with mem word 4 = 0xDEAD_BEEF -> gnt same cycle, rvalid+rdata next.
//  - DMA only: store 0x1234_5678 @0x20, be=4'hF -> mem_we=1, mem_addr=8, dma_gnt=1, no stall.
//  - Contention: both req held 10 cycles, MAX_CORE_BURST=4 -> core 4 grants, DMA 1, repeat; stall
//    high only on DMA slot cycles.
//  - Out of range: core load @0x0000_2000 -> mem_req_o=0, next cycle rvalid=1, rdata=0.
//  - Back-to-back: core load @0x4 then DMA load @0x8 -> rdata routed to core then DMA, no cross-leak.
//  - Reset asserted the cycle after a core load grant -> no core_rvalid_o, burst_cnt=0, state ARB_CORE.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the data-memory arbiter: FSM states, response owner and
// the request bundle steered onto the memory port.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic {
        ARB_CORE,
        ARB_DMA_FORCED
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CORE,
        OWN_DMA
    } arb_owner_e;

    typedef struct packed {
        logic            we;
        logic [3:0]      be;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/dmem_arb_fair_cnt.sv
// Counts consecutive core grants while DMA waits and flags the forced DMA slot
// once the core has had MAX_CORE_BURST grants in a row.
module dmem_arb_fair_cnt
    import riscv_pkg::*;
#(
    parameter int MAX_CORE_BURST = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic dma_req_i,
    input  logic core_gnt_i,
    input  logic dma_gnt_i,
    output logic forced_o
);

    localparam int CNT_W = $clog2(MAX_CORE_BURST + 1);

    arb_state_e       state_reg;
    logic [CNT_W-1:0] burst_cnt_reg;
    logic [CNT_W-1:0] burst_cnt_next;

    assign burst_cnt_next = burst_cnt_reg + 1'b1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg     <= ARB_CORE;
            burst_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ARB_CORE: begin
                    if (!dma_req_i || dma_gnt_i) begin
                        burst_cnt_reg <= '0;
                    end else if (core_gnt_i) begin
                        burst_cnt_reg <= burst_cnt_next;
                        if (burst_cnt_next == CNT_W'(MAX_CORE_BURST)) begin
                            state_reg <= ARB_DMA_FORCED;
                        end
                    end
                end
                // Either DMA takes the slot or it has gone idle; both end the burst.
                ARB_DMA_FORCED: begin
                    state_reg     <= ARB_CORE;
                    burst_cnt_reg <= '0;
                end
                default: begin
                    state_reg     <= ARB_CORE;
                    burst_cnt_reg <= '0;
                end
            endcase
        end
    end

    assign forced_o = (state_reg == ARB_DMA_FORCED);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core MEM stage and the DMA port;
// core wins by default, with a periodic forced DMA slot, and routes load data back.
module dmem_arbiter
    import riscv_pkg::*;
#(
    parameter int ADDR_W         = 13,
    parameter int MAX_CORE_BURST = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [3:0]        core_be_i,
    input  logic [XLEN-1:0]   core_addr_i,
    input  logic [XLEN-1:0]   core_wdata_i,
    output logic              core_gnt_o,
    output logic              core_stall_o,
    output logic              core_rvalid_o,
    output logic [XLEN-1:0]   core_rdata_o,
    input  logic              dma_req_i,
    input  logic              dma_we_i,
    input  logic [3:0]        dma_be_i,
    input  logic [XLEN-1:0]   dma_addr_i,
    input  logic [XLEN-1:0]   dma_wdata_i,
    output logic              dma_gnt_o,
    output logic              dma_rvalid_o,
    output logic [XLEN-1:0]   dma_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-3:0] mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic [XLEN-1:0]   mem_rdata_i
);

    logic       forced;
    logic       core_gnt;
    logic       dma_gnt;
    logic       any_gnt;
    logic       in_range;
    logic       issue;
    logic       addr_lsb_unused;
    mem_req_t   sel_req;
    arb_owner_e resp_owner_reg;
    logic       resp_zero_reg;

    dmem_arb_fair_cnt #(
        .MAX_CORE_BURST(MAX_CORE_BURST)
    ) u_fair_cnt (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .dma_req_i (dma_req_i),
        .core_gnt_i(core_gnt),
        .dma_gnt_i (dma_gnt),
        .forced_o  (forced)
    );

    // The core only loses the port during a forced slot that DMA actually uses.
    assign core_gnt = core_req_i & ~(forced & dma_req_i);
    assign dma_gnt  = dma_req_i & (forced | ~core_req_i);
    assign any_gnt  = core_gnt | dma_gnt;

    always_comb begin
        sel_req = '0;
        if (core_gnt) begin
            sel_req = '{we: core_we_i, be: core_be_i, addr: core_addr_i, wdata: core_wdata_i};
        end else if (dma_gnt) begin
            sel_req = '{we: dma_we_i, be: dma_be_i, addr: dma_addr_i, wdata: dma_wdata_i};
        end
    end

    assign in_range        = (sel_req.addr[XLEN-1:ADDR_W] == '0);
    assign issue           = any_gnt & in_range;
    assign addr_lsb_unused = ^sel_req.addr[1:0];

    assign mem_req_o   = issue;
    assign mem_we_o    = issue & sel_req.we;
    assign mem_be_o    = sel_req.be;
    assign mem_addr_o  = sel_req.addr[ADDR_W-1:2];
    assign mem_wdata_o = sel_req.wdata;

    // Out-of-range loads still complete, but with forced-zero data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp_owner_reg <= OWN_NONE;
            resp_zero_reg  <= 1'b0;
        end else begin
            resp_zero_reg <= ~in_range;
            if (any_gnt && !sel_req.we) begin
                resp_owner_reg <= core_gnt ? OWN_CORE : OWN_DMA;
            end else begin
                resp_owner_reg <= OWN_NONE;
            end
        end
    end

    assign core_rvalid_o = (resp_owner_reg == OWN_CORE);
    assign dma_rvalid_o  = (resp_owner_reg == OWN_DMA);
    assign core_rdata_o  = (core_rvalid_o && !resp_zero_reg) ? mem_rdata_i : '0;
    assign dma_rdata_o   = (dma_rvalid_o && !resp_zero_reg) ? mem_rdata_i : '0;

    assign core_gnt_o   = core_gnt;
    assign dma_gnt_o    = dma_gnt;
    assign core_stall_o = core_req_i & ~core_gnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural memory and a per-cycle
// response scoreboard.
module tb_dmem_arbiter;

    typedef struct packed {
        logic        cv;
        logic [31:0] cd;
        logic        dv;
        logic [31:0] dd;
    } resp_t;

    logic        clk;
    logic        rst;
    logic        core_req, core_we;
    logic [3:0]  core_be;
    logic [31:0] core_addr, core_wdata;
    logic        core_gnt, core_stall, core_rvalid;
    logic [31:0] core_rdata;
    logic        dma_req, dma_we;
    logic [3:0]  dma_be;
    logic [31:0] dma_addr, dma_wdata;
    logic        dma_gnt, dma_rvalid;
    logic [31:0] dma_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [10:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem_model [0:2047];
    logic [31:0] gold [0:2047];
    resp_t       sb[$];
    int          vecs;
    int          errs;

    dmem_arbiter #(
        .ADDR_W        (13),
        .MAX_CORE_BURST(4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .core_req_i   (core_req),
        .core_we_i    (core_we),
        .core_be_i    (core_be),
        .core_addr_i  (core_addr),
        .core_wdata_i (core_wdata),
        .core_gnt_o   (core_gnt),
        .core_stall_o (core_stall),
        .core_rvalid_o(core_rvalid),
        .core_rdata_o (core_rdata),
        .dma_req_i    (dma_req),
        .dma_we_i     (dma_we),
        .dma_be_i     (dma_be),
        .dma_addr_i   (dma_addr),
        .dma_wdata_i  (dma_wdata),
        .dma_gnt_o    (dma_gnt),
        .dma_rvalid_o (dma_rvalid),
        .dma_rdata_o  (dma_rdata),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_be_o     (mem_be),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port memory with one-cycle read latency.
    initial begin
        for (int i = 0; i < 2048; i++) mem_model[i] = 32'hA500_0000 | i;
        mem_model[4] = 32'hDEAD_BEEF;
        mem_rdata <= 32'h0;
        forever begin
            @(posedge clk);
            if (mem_req) begin
                if (mem_we) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_be[b]) mem_model[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end else begin
                    mem_rdata <= mem_model[mem_addr];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] gold_rd(input logic [31:0] a);
        if (a[31:13] != 19'h0) return 32'h0;
        return gold[a[12:2]];
    endfunction

    task automatic drive(input logic cr, input logic cwe, input logic [31:0] ca, input logic [31:0] cw,
                         input logic dr, input logic dwe, input logic [31:0] da, input logic [31:0] dw);
        core_req = cr; core_we = cwe; core_addr = ca; core_wdata = cw; core_be = 4'hF;
        dma_req  = dr; dma_we  = dwe; dma_addr  = da; dma_wdata  = dw; dma_be  = 4'hF;
    endtask

    // Checks grants/stall and last cycle's response, then queues this cycle's response.
    task automatic check_cycle(input logic ecg, input logic edg, input string tag);
        resp_t r;
        resp_t n;
        @(negedge clk);
        chk({tag, ".core_gnt"}, 32'(core_gnt), 32'(ecg));
        chk({tag, ".dma_gnt"}, 32'(dma_gnt), 32'(edg));
        chk({tag, ".stall"}, 32'(core_stall), 32'(core_req & ~ecg));
        r = (sb.size() > 0) ? sb.pop_front() : '0;
        chk({tag, ".core_rvalid"}, 32'(core_rvalid), 32'(r.cv));
        chk({tag, ".core_rdata"}, core_rdata, r.cd);
        chk({tag, ".dma_rvalid"}, 32'(dma_rvalid), 32'(r.dv));
        chk({tag, ".dma_rdata"}, dma_rdata, r.dd);
        n = '0;
        if (ecg && !core_we) begin n.cv = 1'b1; n.cd = gold_rd(core_addr); end
        if (edg && !dma_we)  begin n.dv = 1'b1; n.dd = gold_rd(dma_addr); end
        if (ecg && core_we && core_addr[31:13] == 19'h0) gold[core_addr[12:2]] = core_wdata;
        if (edg && dma_we && dma_addr[31:13] == 19'h0)   gold[dma_addr[12:2]]  = dma_wdata;
        sb.push_back(n);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        for (int i = 0; i < 2048; i++) gold[i] = 32'hA500_0000 | i;
        gold[4] = 32'hDEAD_BEEF;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.core_gnt", 32'(core_gnt), 0);
        chk("rst.dma_gnt", 32'(dma_gnt), 0);
        chk("rst.core_rvalid", 32'(core_rvalid), 0);
        chk("rst.dma_rvalid", 32'(dma_rvalid), 0);
        chk("rst.mem_req", 32'(mem_req), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Core-only load of word 4.
        drive(1, 0, 32'h10, 0, 0, 0, 0, 0);
        check_cycle(1, 0, "core_ld");
        chk("core_ld.mem_req", 32'(mem_req), 1);
        chk("core_ld.mem_addr", 32'(mem_addr), 4);
        chk("core_ld.mem_we", 32'(mem_we), 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check_cycle(0, 0, "core_ld_resp");
        tick();

        // DMA-only store, then read it back through the core.
        drive(0, 0, 0, 0, 1, 1, 32'h20, 32'h1234_5678);
        check_cycle(0, 1, "dma_st");
        chk("dma_st.mem_we", 32'(mem_we), 1);
        chk("dma_st.mem_addr", 32'(mem_addr), 8);
        chk("dma_st.mem_wdata", mem_wdata, 32'h1234_5678);
        tick();
        drive(1, 0, 32'h20, 0, 0, 0, 0, 0);
        check_cycle(1, 0, "rdback");
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check_cycle(0, 0, "rdback_resp");
        tick();

        // Contention: four core grants, then one forced DMA slot, repeating.
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 32'h10, 0, 1, 0, 32'h24, 0);
            check_cycle((i % 5) != 4, (i % 5) == 4, $sformatf("contend%0d", i));
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check_cycle(0, 0, "contend_drain");
        tick();

        // Out-of-range core load.
        drive(1, 0, 32'h2000, 0, 0, 0, 0, 0);
        check_cycle(1, 0, "oor_ld");
        chk("oor_ld.mem_req", 32'(mem_req), 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check_cycle(0, 0, "oor_resp");
        tick();

        // Back-to-back: core load then DMA load.
        drive(1, 0, 32'h4, 0, 0, 0, 0, 0);
        check_cycle(1, 0, "b2b_core");
        tick();
        drive(0, 0, 0, 0, 1, 0, 32'h8, 0);
        check_cycle(0, 1, "b2b_dma");
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check_cycle(0, 0, "b2b_drain");
        tick();

        // Three contended core loads, then reset right after the last grant.
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 32'h10, 0, 1, 0, 32'h24, 0);
            check_cycle(1, 0, $sformatf("pre_rst%0d", i));
            tick();
        end
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("mid_rst.core_rvalid", 32'(core_rvalid), 0);
        sb.delete();
        tick();
        rst = 1'b0;
        check_cycle(0, 0, "post_rst");
        tick();
        // Counter must restart from zero: four core grants before the DMA slot.
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 32'h10, 0, 1, 0, 32'h24, 0);
            check_cycle(i != 4, i == 4, $sformatf("post_rst_contend%0d", i));
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check_cycle(0, 0, "final_drain");
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
